// File: rtl/operand_loader_if.sv
// Switch/button inputs and ALU-facing outputs of operand_loader.
// The board side (master) drives sw and the buttons; the loader (slave) drives the captured values.
interface operand_loader_if #(
  parameter int N = 4
);
  logic [N-1:0] sw;
  logic         btn_next;
  logic         btn_clear;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   op;
  logic         op_sum;
  logic         op_subt;
  logic         valid;
  logic [1:0]   stage;
  logic         err;

  modport master (
    output sw, btn_next, btn_clear,
    input  a, b, op, op_sum, op_subt, valid, stage, err
  );

  modport slave (
    input  sw, btn_next, btn_clear,
    output a, b, op, op_sum, op_subt, valid, stage, err
  );
endinterface

// File: rtl/operand_loader.sv
// Sequential operand/opcode loader in front of the ALU: synchronised buttons, edge pulses, load FSM.
// Define OPERAND_LOADER_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES counter filter per button.
module operand_loader #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic            clk,
  input logic            rst_n,
  operand_loader_if.slave bus
);

  if (N < 4 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("operand_loader: N must be >= 4 and DEBOUNCE_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    RUN     = 2'd3
  } state_t;

  // Button index 0 is next, index 1 is clear.
  logic [1:0] raw;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] lvl;
  logic [1:0] lvl_d;
  logic [1:0] armed;
  logic [1:0] pulse;
  logic [1:0] prime;

  assign raw = {bus.btn_clear, bus.btn_next};

  // A button must be seen released after reset before it may pulse; prime[1] marks
  // the point where s2 reflects real post-reset samples instead of cleared flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      prime <= '0;
      armed <= '0;
      lvl_d <= '0;
      pulse <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      prime <= {prime[0], 1'b1};
      armed <= armed | ({2{prime[1]}} & ~s2);
      lvl_d <= lvl;
      pulse <= lvl & ~lvl_d & armed;
    end
  end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt [2];
  logic [1:0]    filt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt <= '0;
      for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  logic next_p;
  logic clear_p;
  logic [3:0] code;

  assign next_p  = pulse[0];
  assign clear_p = pulse[1];
  assign code    = bus.sw[3:0];

  state_t       state;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [2:0]   op_q;
  logic         sum_q;
  logic         subt_q;
  logic         valid_q;
  logic         err_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_p) begin
      state   <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sum_q   <= 1'b0;
      subt_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (next_p) begin
      case (state)
        LOAD_A: begin
          a_q   <= bus.sw;
          err_q <= 1'b0;
          state <= LOAD_B;
        end
        LOAD_B: begin
          b_q   <= bus.sw;
          err_q <= 1'b0;
          state <= LOAD_OP;
        end
        LOAD_OP: begin
          if (code[3] && (code[2] || code[1])) begin
            err_q <= 1'b1;
          end else begin
            if (!code[3]) begin
              op_q   <= code[2:0];
              sum_q  <= 1'b0;
              subt_q <= 1'b0;
            end else begin
              sum_q  <= ~code[0];
              subt_q <= code[0];
            end
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          err_q   <= 1'b0;
          valid_q <= 1'b0;
          state   <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  assign bus.a       = a_q;
  assign bus.b       = b_q;
  assign bus.op      = op_q;
  assign bus.op_sum  = sum_q;
  assign bus.op_subt = subt_q;
  assign bus.valid   = valid_q;
  assign bus.stage   = state;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader against a press-level behavioural model.
// Build with OPERAND_LOADER_DEBOUNCE_EN to exercise the debounce filter (DEBOUNCE_CYCLES=4).
module tb_operand_loader;
  localparam int N = 4;
  localparam int D = 4;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int LAT = 3 + D;
`else
  localparam int LAT = 3;
`endif
  localparam int W = 2 * N + 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  operand_loader_if #(.N(N)) bus();

  operand_loader #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Press-level model: one accepted press = one step of the entry sequence.
  logic [N-1:0] m_a, m_b;
  logic [2:0]   m_op;
  logic         m_sum, m_subt, m_err;
  int           m_stage;

  logic [W-1:0] obs;
  assign obs = {bus.a, bus.b, bus.op, bus.op_sum, bus.op_subt, bus.valid, bus.stage, bus.err};

  function automatic logic [W-1:0] model_vec();
    return {m_a, m_b, m_op, m_sum, m_subt, (m_stage == 3), 2'(m_stage), m_err};
  endfunction

  function automatic void model_clear();
    m_a = '0; m_b = '0; m_op = '0; m_sum = 0; m_subt = 0; m_err = 0; m_stage = 0;
  endfunction

  function automatic void model_next(input logic [N-1:0] v);
    int code;
    code = int'(v) % 16;
    case (m_stage)
      0: begin m_a = v; m_err = 0; m_stage = 1; end
      1: begin m_b = v; m_err = 0; m_stage = 2; end
      2: begin
        if (code >= 10) m_err = 1;
        else begin
          if (code < 8) begin m_op = 3'(code); m_sum = 0; m_subt = 0; end
          else if (code == 8) begin m_sum = 1; m_subt = 0; end
          else begin m_sum = 0; m_subt = 1; end
          m_err = 0;
          m_stage = 3;
        end
      end
      default: begin m_err = 0; m_stage = 0; end
    endcase
  endfunction

  // Idle long enough to re-arm, press for LAT cycles, return outputs seen just before capture edge.
  task automatic press(input bit dn, input bit dc, input logic [N-1:0] v, output logic [W-1:0] pre);
    repeat (LAT + 1) @(negedge clk);
    bus.sw = v; bus.btn_next = dn; bus.btn_clear = dc;
    repeat (LAT) @(negedge clk);
    pre = obs;
    bus.btn_next = 0; bus.btn_clear = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.sw = '0; bus.btn_next = 0; bus.btn_clear = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    model_clear();
    checks++;
    if (obs !== model_vec()) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs, model_vec()); end
    rst_n = 1;
    repeat (4) @(negedge clk);
    checks++;
    if (obs !== model_vec()) begin errors++; $display("FAIL reset_release: got %h expected %h", obs, model_vec()); end
  endtask

  task automatic test_full_entry();
    logic [N-1:0] seq [3];
    logic [W-1:0] pre, exp_pre;
    seq[0] = 4'b0101; seq[1] = 4'b0011; seq[2] = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      exp_pre = model_vec();
      press(1, 0, seq[i], pre);
      model_next(seq[i]);
      checks++;
      if (pre !== exp_pre) begin errors++; $display("FAIL entry_latency_%0d: got %h expected %h", i, pre, exp_pre); end
      checks++;
      if (obs !== model_vec()) begin errors++; $display("FAIL entry_capture_%0d: got %h expected %h", i, obs, model_vec()); end
    end
    checks++;
    if ({bus.a, bus.b, bus.op_sum, bus.op_subt, bus.valid, bus.stage} !== {4'b0101, 4'b0011, 1'b1, 1'b0, 1'b1, 2'd3}) begin
      errors++; $display("FAIL entry_final: got a=%b b=%b sum=%b subt=%b valid=%b stage=%0d expected a=0101 b=0011 sum=1 subt=0 valid=1 stage=3",
                        bus.a, bus.b, bus.op_sum, bus.op_subt, bus.valid, bus.stage);
    end
  endtask

  task automatic test_opcode_path();
    logic [W-1:0] pre;
    press(1, 0, 4'b0000, pre); model_next(4'b0000);
    press(1, 0, 4'b0111, pre); model_next(4'b0111);
    press(1, 0, 4'b0010, pre); model_next(4'b0010);
    press(1, 0, 4'b0010, pre); model_next(4'b0010);
    checks++;
    if (obs !== model_vec()) begin errors++; $display("FAIL opcode_run: got %h expected %h", obs, model_vec()); end
    press(1, 0, 4'b1111, pre); model_next(4'b1111);
    checks++;
    if (obs !== model_vec()) begin errors++; $display("FAIL opcode_wrap: got %h expected %h", obs, model_vec()); end
  endtask

  task automatic test_illegal();
    logic [W-1:0] pre;
    press(1, 0, 4'b0110, pre); model_next(4'b0110);
    press(1, 0, 4'b1001, pre); model_next(4'b1001);
    press(1, 0, 4'b1100, pre); model_next(4'b1100);
    checks++;
    if (obs !== model_vec() || bus.err !== 1'b1 || bus.stage !== 2'd2) begin
      errors++; $display("FAIL illegal_code: got %h expected %h", obs, model_vec());
    end
    press(1, 0, 4'b1001, pre); model_next(4'b1001);
    checks++;
    if (obs !== model_vec()) begin errors++; $display("FAIL illegal_recover: got %h expected %h", obs, model_vec()); end
  endtask

  task automatic test_clear_simul();
    logic [W-1:0] pre;
    press(1, 0, 4'b0000, pre); model_next(4'b0000);
    press(1, 0, 4'b1111, pre); model_next(4'b1111);
    checks++;
    if (obs !== model_vec()) begin errors++; $display("FAIL clear_setup: got %h expected %h", obs, model_vec()); end
    press(1, 1, 4'b1010, pre); model_clear();
    checks++;
    if (obs !== model_vec()) begin errors++; $display("FAIL clear_simul: got %h expected %h", obs, model_vec()); end
  endtask

  task automatic test_random();
    logic [W-1:0] pre, exp_pre;
    logic [N-1:0] v;
    int r;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      v = N'($urandom);
      exp_pre = model_vec();
      if (r == 0) begin press(0, 1, v, pre); model_clear(); end
      else if (r == 1) begin press(1, 1, v, pre); model_clear(); end
      else begin press(1, 0, v, pre); model_next(v); end
      checks++;
      if (pre !== exp_pre) begin errors++; $display("FAIL random_latency_%0d: got %h expected %h", i, pre, exp_pre); end
      checks++;
      if (obs !== model_vec()) begin errors++; $display("FAIL random_step_%0d: got %h expected %h", i, obs, model_vec()); end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] pre;
    logic [N-1:0] v;
    press(0, 1, '0, pre); model_clear();
    press(1, 0, N'($urandom), pre); model_next(bus.sw);
    press(1, 0, N'($urandom), pre); model_next(bus.sw);
    checks++;
    if (obs !== model_vec() || bus.stage !== 2'd2) begin errors++; $display("FAIL resetmid_setup: got %h expected %h", obs, model_vec()); end
    @(negedge clk);
    bus.btn_next = 1; rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_clear();
    repeat (3 * LAT + 5) @(negedge clk);
    checks++;
    if (obs !== model_vec()) begin errors++; $display("FAIL resetmid_held: got %h expected %h", obs, model_vec()); end
    bus.btn_next = 0;
    v = N'($urandom);
    press(1, 0, v, pre); model_next(v);
    checks++;
    if (obs !== model_vec()) begin errors++; $display("FAIL resetmid_repress: got %h expected %h", obs, model_vec()); end
  endtask

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  task automatic test_debounce();
    logic [W-1:0] exp_pre;
    logic [N-1:0] v;
    repeat (LAT + 1) @(negedge clk);
    bus.sw = N'($urandom); bus.btn_next = 1;
    repeat (D - 1) @(negedge clk);
    bus.btn_next = 0;
    repeat (2 * LAT) @(negedge clk);
    checks++;
    if (obs !== model_vec()) begin errors++; $display("FAIL debounce_glitch: got %h expected %h", obs, model_vec()); end

    exp_pre = model_vec();
    v = N'($urandom);
    bus.sw = v; bus.btn_next = 1;
    repeat (D) @(negedge clk);
    bus.btn_next = 0;
    repeat (LAT - D) @(negedge clk);
    checks++;
    if (obs !== exp_pre) begin errors++; $display("FAIL debounce_early: got %h expected %h", obs, exp_pre); end
    @(negedge clk);
    model_next(v);
    checks++;
    if (obs !== model_vec()) begin errors++; $display("FAIL debounce_capture: got %h expected %h", obs, model_vec()); end

    repeat (2 * LAT) @(negedge clk);
    v = N'($urandom);
    bus.sw = v; bus.btn_next = 1;
    repeat (50) @(negedge clk);
    bus.btn_next = 0;
    repeat (2 * LAT) @(negedge clk);
    model_next(v);
    checks++;
    if (obs !== model_vec()) begin errors++; $display("FAIL debounce_sustained: got %h expected %h", obs, model_vec()); end
  endtask
`endif

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_entry();
    test_opcode_path();
    test_illegal();
    test_clear_simul();
    test_random();
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
